alu_decode_stage: RTL and testbench
===================================

Name: alu_decode_stage

Overview:
Registered instruction-decode stage that drives the other end of the ALU interface. It produces ALUsel and both ALU operands from an RV32I instruction plus register-file read data. It sits between fetch and the combinational ALU and presents one decoded op per cycle under a valid/ready handshake. It also supports backpressure, flush and illegal-instruction flagging.

Parameters:
- DATA_W, 32, operand/PC width (only 32 supported)
- RADDR_W, 5, register index width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  instr/pc/rs data valid
- in_ready  output  1  stage can accept
- instr  input  32  RV32I instruction word
- pc  input  DATA_W  instruction address
- rs1_data  input  DATA_W  regfile read port 1 (same cycle as instr)
- rs2_data  input  DATA_W  regfile read port 2
- flush  input  1  kill held and incoming op
- out_valid  output  1  decoded op valid
- out_ready  input  1  downstream accepts
- alu_sel  output  4  ALUsel to ALU
- op_a  output  DATA_W  ALU reg1
- op_b  output  DATA_W  ALU reg2
- rd_addr  output  RADDR_W  destination register
- reg_write  output  1  writes rd
- is_branch  output  1  conditional branch; funct3 forwarded
- br_funct3  output  3  branch condition code
- link_addr  output  DATA_W  pc+4, for JAL/JALR
- illegal  output  1  undecodable instruction

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0. alu_sel, op_a, op_b, rd_addr, link_addr, br_funct3 = 0. reg_write, is_branch, illegal = 0. Reset overrides flush and handshake.
- alu_sel encodings:
  - AND=0, OR=1, ADD=2, ADD0=3, SLL=4, SRL=5, SUB=6
  - unsigned_SLT=7, signed_SLT=8, SRA=9, JALR=10, XOR=11
- Latency: 1 cycle. Inputs accepted on edge N appear on outputs after edge N.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready.
  - Output register holds stable while out_valid && !out_ready.
  - out_valid drops after a transfer with no new accept.
- Flush: at the edge, out_valid←0 and any simultaneous input is discarded, regardless of out_ready.
- Decode rules:
  - OP: funct7/funct3 select ADD/SUB/SLL/SLT(8)/SLTU(7)/XOR/SRL/SRA/OR/AND. op_a=rs1, op_b=rs2.
  - OP-IMM: same mapping, no SUB. op_b = I-imm sign-extended to 32 bits. Shifts: op_b = {27'b0, shamt}. SRAI requires funct7=0100000. SLLI/SRLI require funct7=0.
  - LUI: ADD0, op_b=U-imm (instr[31:12]<<12).
  - AUIPC: ADD, op_a=pc, op_b=U-imm.
  - JAL: ADD, op_a=pc, op_b=J-imm, reg_write=1.
  - JALR: JALR sel, op_a=rs1, op_b=I-imm, reg_write=1, funct3 must be 0.
  - BRANCH: is_branch=1, reg_write=0.
    - BEQ/BNE: SUB.
    - BLT/BGE: signed_SLT.
    - BLTU/BGEU: unsigned_SLT.
    - funct3 010/011 are illegal.
  - LOAD/STORE: ADD, op_a=rs1. op_b = I-imm (load) or S-imm (store). reg_write = load only.
  - rd=x0 forces reg_write=0.
- Illegal (any other opcode or reserved funct field): illegal=1, reg_write=0, is_branch=0, alu_sel=ADD, op_a=op_b=0. The op still transfers with out_valid=1.
- link_addr = pc+4 mod 2^32 (wraps at 0xFFFFFFFC → 0).

Optional Feature:
SKID_BUF_EN
- Defined: adds one skid entry so in_ready is a pure register output (= !skid_valid).
  - An input accepted while the output is stalled is stored in the skid entry.
  - The skid entry moves to the output on the next out_ready.
  - Order is preserved. Flush clears both entries.
  - Zero-bubble throughput is kept.
- Undefined: single output register, combinational in_ready as above.

Test Plan:
1. Reset then instr=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, alu_sel=2, op_a=5, op_b=7, rd_addr=3, reg_write=1.
2. instr=0xFFF00093 (addi x1,x0,-1), rs1=0 → alu_sel=2, op_b=0xFFFFFFFF, rd_addr=1; instr=0x4030D093 (srai x1,x1,3) → alu_sel=9, op_b=3.
3. out_ready=0, two back-to-back valid inputs → first op held unchanged and in_ready=0 (SKID_BUF_EN: second captured, in_ready=0 next). After out_ready=1 both emerge in order, no loss or duplication.
4. instr=0x0020C463 (blt x1,x2,+8) → alu_sel=8, is_branch=1, br_funct3=4, reg_write=0; instr=0x00000067 (jalr x0,0(x0)) with pc=0xFFFFFFFC → alu_sel=10, reg_write=0, link_addr=0.
5. instr=0xFFFFFFFF → illegal=1, out_valid=1, reg_write=0, alu_sel=2.
6. out_valid=1, out_ready=0, flush=1 with in_valid=1 → next cycle out_valid=0, input dropped; rst_n=0 mid-stall → all outputs 0 next edge.

Source files
------------

// File: rtl/alu_decode_stage_if.sv
// Decode-stage bus: fetch/regfile inputs, decoded ALU op outputs, valid/ready on both sides.
// master = decode stage, slave = surrounding fetch/ALU environment.
interface alu_decode_stage_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        instr;
  logic [DATA_W-1:0]  pc;
  logic [DATA_W-1:0]  rs1_data;
  logic [DATA_W-1:0]  rs2_data;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         alu_sel;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic [RADDR_W-1:0] rd_addr;
  logic               reg_write;
  logic               is_branch;
  logic [2:0]         br_funct3;
  logic [DATA_W-1:0]  link_addr;
  logic               illegal;

  modport master (
    input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, alu_sel, op_a, op_b, rd_addr, reg_write,
           is_branch, br_funct3, link_addr, illegal
  );

  modport slave (
    output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, alu_sel, op_a, op_b, rd_addr, reg_write,
           is_branch, br_funct3, link_addr, illegal
  );
endinterface

// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage feeding the ALU (ALUsel + operands), valid/ready handshake.
// Ports: clk, rst_n (sync, active-low), bus (alu_decode_stage_if.master).
// Optional SKID_BUF_EN: one skid entry, in_ready becomes a register output.
module alu_decode_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_decode_stage_if.master  bus
);

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_ADD0 = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_JALR = 4'd10;
  localparam logic [3:0] ALU_XOR  = 4'd11;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]         alu_sel;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [RADDR_W-1:0] rd_addr;
    logic               reg_write;
    logic               is_branch;
    logic [2:0]         br_funct3;
    logic [DATA_W-1:0]  link_addr;
    logic               illegal;
  } dec_t;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [DATA_W-1:0] imm_i;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] imm_u;
  logic [DATA_W-1:0] imm_j;
  logic [DATA_W-1:0] shamt;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign imm_i  = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s  = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_u  = {bus.instr[31:12], 12'b0};
  assign imm_j  = {{12{bus.instr[31]}}, bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0};
  assign shamt  = {27'b0, bus.instr[24:20]};

  dec_t dec;
  logic legal;
  logic writes;

  always_comb begin
    dec           = '0;
    dec.alu_sel   = ALU_ADD;
    dec.rd_addr   = bus.instr[11:7];
    dec.link_addr = bus.pc + DATA_W'(4);
    legal         = 1'b1;
    writes        = 1'b0;

    case (opcode)
      OPC_OP: begin
        dec.op_a = bus.rs1_data;
        dec.op_b = bus.rs2_data;
        writes   = 1'b1;
        case ({funct7, funct3})
          {F7_ZERO, 3'b000}: dec.alu_sel = ALU_ADD;
          {F7_ALT,  3'b000}: dec.alu_sel = ALU_SUB;
          {F7_ZERO, 3'b001}: dec.alu_sel = ALU_SLL;
          {F7_ZERO, 3'b010}: dec.alu_sel = ALU_SLT;
          {F7_ZERO, 3'b011}: dec.alu_sel = ALU_SLTU;
          {F7_ZERO, 3'b100}: dec.alu_sel = ALU_XOR;
          {F7_ZERO, 3'b101}: dec.alu_sel = ALU_SRL;
          {F7_ALT,  3'b101}: dec.alu_sel = ALU_SRA;
          {F7_ZERO, 3'b110}: dec.alu_sel = ALU_OR;
          {F7_ZERO, 3'b111}: dec.alu_sel = ALU_AND;
          default:           legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec.op_a = bus.rs1_data;
        dec.op_b = imm_i;
        writes   = 1'b1;
        case (funct3)
          3'b000: dec.alu_sel = ALU_ADD;
          3'b010: dec.alu_sel = ALU_SLT;
          3'b011: dec.alu_sel = ALU_SLTU;
          3'b100: dec.alu_sel = ALU_XOR;
          3'b110: dec.alu_sel = ALU_OR;
          3'b111: dec.alu_sel = ALU_AND;
          3'b001: begin
            dec.op_b    = shamt;
            dec.alu_sel = ALU_SLL;
            legal       = (funct7 == F7_ZERO);
          end
          default: begin
            dec.op_b = shamt;
            if (funct7 == F7_ZERO)     dec.alu_sel = ALU_SRL;
            else if (funct7 == F7_ALT) dec.alu_sel = ALU_SRA;
            else                       legal = 1'b0;
          end
        endcase
      end
      OPC_LUI: begin
        dec.alu_sel = ALU_ADD0;
        dec.op_b    = imm_u;
        writes      = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op_a = bus.pc;
        dec.op_b = imm_u;
        writes   = 1'b1;
      end
      OPC_JAL: begin
        dec.op_a = bus.pc;
        dec.op_b = imm_j;
        writes   = 1'b1;
      end
      OPC_JALR: begin
        dec.alu_sel = ALU_JALR;
        dec.op_a    = bus.rs1_data;
        dec.op_b    = imm_i;
        writes      = 1'b1;
        legal       = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        dec.op_a      = bus.rs1_data;
        dec.op_b      = bus.rs2_data;
        dec.is_branch = 1'b1;
        dec.br_funct3 = funct3;
        case (funct3)
          3'b000, 3'b001: dec.alu_sel = ALU_SUB;
          3'b100, 3'b101: dec.alu_sel = ALU_SLT;
          3'b110, 3'b111: dec.alu_sel = ALU_SLTU;
          default:        legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec.op_a = bus.rs1_data;
        dec.op_b = imm_i;
        writes   = 1'b1;
        legal    = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OPC_STORE: begin
        dec.op_a = bus.rs1_data;
        dec.op_b = imm_s;
        legal    = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
      default: legal = 1'b0;
    endcase

    if (legal) begin
      dec.reg_write = writes && (bus.instr[11:7] != 5'd0);
    end else begin
      dec.alu_sel   = ALU_ADD;
      dec.op_a      = '0;
      dec.op_b      = '0;
      dec.reg_write = 1'b0;
      dec.is_branch = 1'b0;
      dec.br_funct3 = '0;
      dec.illegal   = 1'b1;
    end
  end

  dec_t out_q;
  logic out_valid;
  logic in_ready;
  logic accept;

`ifdef SKID_BUF_EN
  dec_t skid_q;
  logic skid_valid;

  assign in_ready = !skid_valid;
  assign accept   = bus.in_valid && in_ready;

  // Skid only fills while the output is stalled; it drains before any new accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (bus.flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_valid && !bus.out_ready) begin
      if (accept) begin
        skid_valid <= 1'b1;
        skid_q     <= dec;
      end
    end else if (skid_valid) begin
      out_q      <= skid_q;
      out_valid  <= 1'b1;
      skid_valid <= 1'b0;
    end else if (accept) begin
      out_q     <= dec;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !out_valid || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (bus.flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_q     <= dec;
      out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.alu_sel   = out_q.alu_sel;
  assign bus.op_a      = out_q.op_a;
  assign bus.op_b      = out_q.op_b;
  assign bus.rd_addr   = out_q.rd_addr;
  assign bus.reg_write = out_q.reg_write;
  assign bus.is_branch = out_q.is_branch;
  assign bus.br_funct3 = out_q.br_funct3;
  assign bus.link_addr = out_q.link_addr;
  assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
module tb_alu_decode_stage;

  logic clk;
  logic rst_n;

  alu_decode_stage_if #(.DATA_W(32), .RADDR_W(5)) bus ();

  alu_decode_stage #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  alu_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        is_branch;
    logic [2:0]  br_funct3;
    logic [31:0] link_addr;
    logic        illegal;
  } exp_t;

  exp_t sb[$];
  int unsigned n_compared;
  int unsigned n_mismatched;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] alu, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic rw, input logic br,
                              input logic [2:0] f3, input logic [31:0] link, input logic ill);
    exp_t e;
    e.alu_sel = alu; e.op_a = a; e.op_b = b; e.rd_addr = rd; e.reg_write = rw;
    e.is_branch = br; e.br_funct3 = f3; e.link_addr = link; e.illegal = ill;
    return e;
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_alu_sel"},   32'(bus.alu_sel),   32'd0);
    check({tag, "_op_a"},      bus.op_a,           32'd0);
    check({tag, "_op_b"},      bus.op_b,           32'd0);
    check({tag, "_rd_addr"},   32'(bus.rd_addr),   32'd0);
    check({tag, "_reg_write"}, 32'(bus.reg_write), 32'd0);
    check({tag, "_is_branch"}, 32'(bus.is_branch), 32'd0);
    check({tag, "_br_funct3"}, 32'(bus.br_funct3), 32'd0);
    check({tag, "_link_addr"}, bus.link_addr,      32'd0);
    check({tag, "_illegal"},   32'(bus.illegal),   32'd0);
  endtask

  // Scoreboard consumer: every completed output transfer is compared to the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("alu_sel",   32'(bus.alu_sel),   32'(e.alu_sel));
        check("op_a",      bus.op_a,           e.op_a);
        check("op_b",      bus.op_b,           e.op_b);
        check("rd_addr",   32'(bus.rd_addr),   32'(e.rd_addr));
        check("reg_write", 32'(bus.reg_write), 32'(e.reg_write));
        check("is_branch", 32'(bus.is_branch), 32'(e.is_branch));
        check("br_funct3", 32'(bus.br_funct3), 32'(e.br_funct3));
        check("link_addr", bus.link_addr,      e.link_addr);
        check("illegal",   32'(bus.illegal),   32'(e.illegal));
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pcv,
                      input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
    bit ok;
    int unsigned n;
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    bus.pc       = pcv;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (ok) sb.push_back(e);
    else    check("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.instr    = '0;
    bus.pc       = '0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // add, addi -1, srai, sub, lui, auipc, jal, sw
    send(32'h002081B3, 32'h0000_0100, 32'd5, 32'd7,
         mk(4'd2, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 3'd0, 32'h0000_0104, 1'b0));
    send(32'hFFF00093, 32'h0000_0104, 32'd0, 32'd9,
         mk(4'd2, 32'd0, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0, 3'd0, 32'h0000_0108, 1'b0));
    send(32'h4030D093, 32'h0000_0108, 32'hFFFF_FFFF, 32'd0,
         mk(4'd9, 32'hFFFF_FFFF, 32'd3, 5'd1, 1'b1, 1'b0, 3'd0, 32'h0000_010C, 1'b0));
    send(32'h40208233, 32'h0000_010C, 32'd20, 32'd6,
         mk(4'd6, 32'd20, 32'd6, 5'd4, 1'b1, 1'b0, 3'd0, 32'h0000_0110, 1'b0));
    send(32'h123452B7, 32'h0000_0110, 32'hAAAA_AAAA, 32'd0,
         mk(4'd3, 32'd0, 32'h1234_5000, 5'd5, 1'b1, 1'b0, 3'd0, 32'h0000_0114, 1'b0));
    send(32'hFFFFF317, 32'h0000_0114, 32'd0, 32'd0,
         mk(4'd2, 32'h0000_0114, 32'hFFFF_F000, 5'd6, 1'b1, 1'b0, 3'd0, 32'h0000_0118, 1'b0));
    send(32'h010000EF, 32'h0000_0118, 32'd0, 32'd0,
         mk(4'd2, 32'h0000_0118, 32'd16, 5'd1, 1'b1, 1'b0, 3'd0, 32'h0000_011C, 1'b0));
    send(32'h0020A423, 32'h0000_011C, 32'h0000_1000, 32'd77,
         mk(4'd2, 32'h0000_1000, 32'd8, 5'd8, 1'b0, 1'b0, 3'd0, 32'h0000_0120, 1'b0));

    // blt, jalr x0 with pc wrap, all-ones illegal, reserved branch funct3
    send(32'h0020C463, 32'h0000_0200, 32'd3, 32'd4,
         mk(4'd8, 32'd3, 32'd4, 5'd8, 1'b0, 1'b1, 3'd4, 32'h0000_0204, 1'b0));
    send(32'h00000067, 32'hFFFF_FFFC, 32'h0000_0040, 32'd0,
         mk(4'd10, 32'h0000_0040, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0, 32'h0000_0000, 1'b0));
    send(32'hFFFFFFFF, 32'h0000_0300, 32'h1111_1111, 32'h2222_2222,
         mk(4'd2, 32'd0, 32'd0, 5'd31, 1'b0, 1'b0, 3'd0, 32'h0000_0304, 1'b1));
    send(32'h0020A063, 32'h0000_0304, 32'd1, 32'd2,
         mk(4'd2, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0, 32'h0000_0308, 1'b1));
    drain();

    // Backpressure: second op must wait, first op must stay put.
    bus.out_ready = 1'b0;
    fork
      begin
        send(32'h0020F1B3, 32'h0000_0400, 32'h0000_00F0, 32'h0000_003C,
             mk(4'd0, 32'h0000_00F0, 32'h0000_003C, 5'd3, 1'b1, 1'b0, 3'd0, 32'h0000_0404, 1'b0));
        send(32'h0020E233, 32'h0000_0404, 32'h0000_0F00, 32'h0000_000F,
             mk(4'd1, 32'h0000_0F00, 32'h0000_000F, 5'd4, 1'b1, 1'b0, 3'd0, 32'h0000_0408, 1'b0));
      end
      begin
        repeat (2) @(negedge clk);
        check("stall_hold_op_a_early", bus.op_a, 32'h0000_00F0);
        repeat (2) @(negedge clk);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_hold_op_a", bus.op_a, 32'h0000_00F0);
        check("stall_hold_alu_sel", 32'(bus.alu_sel), 32'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Flush kills the held op and the simultaneous input.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h002081B3;
    bus.pc        = 32'h0000_0500;
    bus.rs1_data  = 32'd1;
    bus.rs2_data  = 32'd2;
    @(posedge clk);
    #1;
    check("flush_pre_out_valid", 32'(bus.out_valid), 32'd1);
    bus.instr = 32'h40208233;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("flush_input_dropped", 32'(bus.out_valid), 32'd0);

    // Reset while stalled clears everything.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h010000EF;
    bus.pc        = 32'h0000_0600;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("rst_pre_out_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_cleared("midstall_reset");
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    check("final_queue_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
